// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared constants, FSM state and data types for the PE MAC unit
package pe_pkg;

    localparam int PE_DATA_W = 16;
    localparam int PE_FRAC_W = 8;
    localparam int PE_TAPS   = 9;
    localparam int PE_ACC_W  = 40;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        OUTPUT
    } pe_mac_state_t;

    typedef logic signed [PE_DATA_W-1:0] pe_data_t;

endpackage

// File: rtl/pe_mac_unit_if.sv
// rtl/pe_mac_unit_if.sv - tap input and result output handshake bundle of the PE MAC unit
interface pe_mac_unit_if
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W
);
    logic                     w_valid;
    logic signed [DATA_W-1:0] w_data;
    logic                     a_valid;
    logic signed [DATA_W-1:0] a_data;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;

    modport master (
        output w_valid, w_data, a_valid, a_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/pe_round_sat.sv
// rtl/pe_round_sat.sv - round-half-up, saturate to DATA_W, optional ReLU (macro PE_RELU_EN)
module pe_round_sat
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int FRAC_W = PE_FRAC_W,
    parameter int ACC_W  = PE_ACC_W
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] result
);
    // One guard bit so the rounding bias can never wrap the sum
    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = -SW'(2 ** (DATA_W - 1));
    localparam logic signed [SW-1:0] BIAS  = SW'(2 ** (FRAC_W - 1));

    logic signed [SW-1:0]     biased;
    logic signed [SW-1:0]     shifted;
    logic signed [DATA_W-1:0] sat;

    always_comb begin
        biased  = {acc[ACC_W-1], acc} + BIAS;
        shifted = biased >>> FRAC_W;
        if (shifted > MAX_V) begin
            sat = MAX_V[DATA_W-1:0];
        end else if (shifted < MIN_V) begin
            sat = MIN_V[DATA_W-1:0];
        end else begin
            sat = shifted[DATA_W-1:0];
        end
    end

`ifdef PE_RELU_EN
    assign result = sat[DATA_W-1] ? '0 : sat;
`else
    assign result = sat;
`endif

endmodule

// File: rtl/pe_mac_unit.sv
// rtl/pe_mac_unit.sv - 3x3 kernel multiply-accumulate with rounded, saturated handshake output
module pe_mac_unit
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int FRAC_W = PE_FRAC_W,
    parameter int TAPS   = PE_TAPS,
    parameter int ACC_W  = PE_ACC_W
) (
    input  logic          clk,
    input  logic          rst,
    pe_mac_unit_if.slave  bus
);
    localparam int PW    = 2 * DATA_W;
    localparam int CNT_W = $clog2(TAPS);

    pe_mac_state_t            state, state_nxt;
    logic [CNT_W-1:0]         tap_cnt;
    logic                     drain_cnt;
    logic signed [PW-1:0]     mul_q;
    logic                     mul_vld;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] out_data_q;
    logic signed [DATA_W-1:0] rs_result;
    logic                     accept;
    logic                     last_tap;
    logic                     out_hs;

    assign accept   = bus.w_valid && bus.a_valid && (state == ACCUM);
    assign last_tap = (tap_cnt == CNT_W'(TAPS - 1));
    assign out_hs   = (state == OUTPUT) && bus.out_ready;

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == OUTPUT);
    assign bus.busy      = (state != ACCUM);
    assign bus.out_data  = out_data_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last_tap) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt)          state_nxt = OUTPUT;
            OUTPUT:  if (bus.out_ready)      state_nxt = ACCUM;
            default:                         state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Two DRAIN cycles: one for the product register, one for the accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt    <= '0;
            drain_cnt  <= 1'b0;
            mul_q      <= '0;
            mul_vld    <= 1'b0;
            acc        <= '0;
            out_data_q <= '0;
        end else begin
            if (accept) begin
                tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;

            mul_vld <= accept;
            if (accept) begin
                mul_q <= PW'(bus.w_data) * PW'(bus.a_data);
            end

            if (out_hs) begin
                acc <= '0;
            end else if (mul_vld) begin
                acc <= acc + ACC_W'(mul_q);
            end

            if (state == DRAIN && drain_cnt) begin
                out_data_q <= rs_result;
            end
        end
    end

    pe_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_round_sat (
        .acc    (acc),
        .result (rs_result)
    );

endmodule

// File: tb/tb_pe_mac_unit.sv
// tb/tb_pe_mac_unit.sv - directed self-checking bench for pe_mac_unit and pe_round_sat
module tb_pe_mac_unit;
    import pe_pkg::*;

`ifdef PE_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic signed [39:0] rs_acc;
    pe_data_t           rs_res;

    pe_mac_unit_if #(.DATA_W(16)) bus ();

    pe_mac_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pe_round_sat u_rs (
        .acc    (rs_acc),
        .result (rs_res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mdl(input logic [15:0] v);
        if (RELU && v[15]) return 16'h0000;
        return v;
    endfunction

    task automatic take_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_cleared"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input logic [15:0] exp_v);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
        else check({tag, "_timeout"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_data"}, {16'h0, bus.out_data}, {16'h0, exp_v});
    endtask

    task automatic kernel(input string tag, input logic [15:0] w0, input logic [15:0] a0,
                          input logic [15:0] wr, input logic [15:0] ar,
                          input logic [15:0] exp_v, input bit take);
        for (int i = 0; i < 9; i++) begin
            bus.w_valid = 1'b1;
            bus.a_valid = 1'b1;
            bus.w_data  = (i == 0) ? w0 : wr;
            bus.a_data  = (i == 0) ? a0 : ar;
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0;
        bus.a_valid = 1'b0;
        check({tag, "_in_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        wait_result(tag, 3, exp_v);
        if (take) take_result(tag);
    endtask

    initial begin
        int acc_cnt;
        bus.w_valid   = 1'b0;
        bus.a_valid   = 1'b0;
        bus.w_data    = '0;
        bus.a_data    = '0;
        bus.out_ready = 1'b0;
        rs_acc        = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_out_data", {16'h0, bus.out_data}, 32'd0);

        // round_sat standalone
        rs_acc = 40'sh7F; #1;
        check("rs_below_half", {16'h0, rs_res}, 32'h0000);
        rs_acc = 40'sh80; #1;
        check("rs_half_up", {16'h0, rs_res}, 32'h0001);
        rs_acc = 40'(-129); #1;
        check("rs_neg", {16'h0, rs_res}, {16'h0, mdl(16'hFFFF)});
        rs_acc = 40'sh80_0000_0000; #1;
        check("rs_neg_sat", {16'h0, rs_res}, {16'h0, mdl(16'h8000)});

        // out_ready while idle has no effect
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("idle_ready_valid", {31'd0, bus.out_valid}, 32'd0);
        check("idle_ready_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // lone w_valid / a_valid consumes nothing; unity kernel result stays exact
        bus.w_valid = 1'b1; bus.w_data = 16'h7FFF; bus.a_data = 16'h7FFF;
        @(posedge clk); #1;
        bus.w_valid = 1'b0; bus.a_valid = 1'b1;
        @(posedge clk); #1;
        bus.a_valid = 1'b0;

        kernel("unity", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0900, 1);
        kernel("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1);
        kernel("sat_neg", 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, mdl(16'h8000), 1);
        kernel("rnd_pos", 16'h0001, 16'h0080, 16'h0000, 16'h0000, 16'h0001, 1);
        kernel("rnd_zero", 16'hFFFF, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 1);
        kernel("rnd_neg", 16'hFFFF, 16'h0081, 16'h0000, 16'h0000, mdl(16'hFFFF), 1);

        // a_valid toggling with w_valid held: 9 accepts in 18 cycles
        acc_cnt = 0;
        bus.w_valid = 1'b1;
        bus.w_data  = 16'h0100;
        bus.a_data  = 16'h0100;
        for (int i = 0; i < 18; i++) begin
            bus.a_valid = (i % 2 == 0);
            if (bus.w_valid && bus.a_valid && bus.in_ready) acc_cnt++;
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0;
        bus.a_valid = 1'b0;
        check("gaps_accepts", acc_cnt, 32'd9);
        wait_result("gaps", 0, 16'h0900);
        take_result("gaps");

        // backpressure: result holds, input beats are not consumed
        kernel("bp", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0900, 0);
        for (int i = 0; i < 5; i++) begin
            bus.w_valid = 1'b1; bus.a_valid = 1'b1;
            bus.w_data  = 16'h7FFF; bus.a_data = 16'h7FFF;
            @(posedge clk); #1;
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_data", {16'h0, bus.out_data}, 32'h0900);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.w_valid = 1'b0; bus.a_valid = 1'b0;
        take_result("bp");
        kernel("bp_next", 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h1200, 1);

        // async reset while a result is pending
        kernel("pre_rst", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0900, 0);
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid_async", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data_async", {16'h0, bus.out_data}, 32'd0);
        check("rst_busy_async", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // async reset mid-kernel after 4 taps, then a clean kernel
        bus.w_valid = 1'b1; bus.a_valid = 1'b1;
        bus.w_data  = 16'h0100; bus.a_data = 16'h0100;
        repeat (4) begin @(posedge clk); #1; end
        bus.w_valid = 1'b0; bus.a_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_mid_out_data", {16'h0, bus.out_data}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        kernel("post_rst", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0900, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_mac_unit.md
Name: pe_mac_unit

Overview:
Downstream consumer of the weight FIFO's serial 16-bit weight stream. It pairs each weight with one 16-bit activation and multiply-accumulates one 3x3 kernel window (TAPS products). It then rounds and saturates the sum to 16 bits and presents it with a valid/ready handshake to the PE output collector. All data is signed Q8.8 fixed point.

Parameters:
DATA_W, 16, width of weight, activation and result words (signed)
FRAC_W, 8, fractional bits of the Q format
TAPS, 9, products accumulated per output (3 serial weights x 3 words)
ACC_W, 40, accumulator width; must be >= 2*DATA_W + clog2(TAPS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
w_valid  in  1  weight word valid (from weight FIFO serial output)
w_data  in  DATA_W  signed weight
a_valid  in  1  activation valid
a_data  in  DATA_W  signed activation
in_ready  out  1  unit accepts a tap this cycle
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  rounded, saturated signed result
busy  out  1  high in DRAIN or OUTPUT state

Behaviour:
- Clocking: one clock; rst is asynchronous, active-high.
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_data=0, busy=0, tap_cnt=0, acc=0, mul register and its valid=0.
- Tap accept: w_valid && a_valid && in_ready, in one cycle. Both operands are consumed together; neither is consumed alone.
- in_ready = (state==ACCUM). It is registered-state only and never depends on w_valid, a_valid or out_ready.
- Pipeline:
  - Stage 1 registers the full-width signed product (2*DATA_W bits) and its valid.
  - Stage 2 sign-extends the product to ACC_W and adds it into acc.
- State ACCUM:
  - tap_cnt increments per accept.
  - An accept with tap_cnt==TAPS-1 moves to DRAIN and resets tap_cnt to 0.
- State DRAIN: lasts exactly 2 cycles, so the last product reaches acc. Then go to OUTPUT.
- Entering OUTPUT:
  - out_data is registered from round_sat(acc) and out_valid=1.
  - Latency: last tap accepted at cycle t, out_valid first high at t+3.
- State OUTPUT:
  - out_valid and out_data hold stable until out_valid && out_ready.
  - On that handshake: out_valid=0, acc=0, state=ACCUM. in_ready is high the next cycle.
  - There is no overlap: the next kernel cannot start until the result is taken.
- round_sat:
  - r = (acc + 2^(FRAC_W-1)) >>> FRAC_W, an arithmetic shift, round-half-up.
  - Clamp r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- The accumulator never wraps for legal parameters; ACC_W headroom guarantees this.
- Boundary conditions:
  - w_valid or a_valid alone: no state change.
  - Inputs asserted during DRAIN or OUTPUT: ignored, not consumed.
  - out_ready high while out_valid=0: no effect.
  - Reset mid-kernel or mid-output: partial sum and pending result are discarded; all registers return to reset values immediately.

Optional Feature:
PE_RELU_EN
- Defined: the result passes through ReLU after round_sat. Any negative saturated value becomes 0, so out_data is never negative.
- Undefined: signed result is output unchanged. No ReLU logic is synthesised.

Decomposition:
- Package pe_pkg holds:
  - default DATA_W/FRAC_W/TAPS/ACC_W constants
  - state enum pe_mac_state_t {ACCUM, DRAIN, OUTPUT}
  - signed data typedef pe_data_t
- Sub-module pe_round_sat: combinational ACC_W to DATA_W rounding, saturation and optional ReLU. It is instantiated once on the acc to out_data path so the bench can test it standalone.

Test Plan:
1. Unity kernel: 9 taps of w=0x0100, a=0x0100 back-to-back -> out_data=0x0900, out_valid high exactly 3 cycles after the 9th accept, in_ready low from the cycle after the 9th accept.
2. Saturation: 9 taps w=0x7FFF, a=0x7FFF -> out_data=0x7FFF. 9 taps w=0x8000, a=0x7FFF -> 0x8001*... clamps to 0x8000. With PE_RELU_EN, the second case gives 0x0000.
3. Rounding: one tap w=0x0001, a=0x0080, 8 zero taps -> out_data=0x0001. One tap w=0xFFFF, a=0x0080, others zero -> out_data=0x0000. One tap w=0xFFFF, a=0x0081 -> out_data=0xFFFF.
4. Handshake gaps: w_valid held high, a_valid toggled every cycle (18 cycles) -> exactly 9 accepts and the same result as scenario 1.
5. Backpressure: out_ready low 5 cycles after out_valid -> out_valid and out_data stable, in_ready=0, w_valid/a_valid beats not consumed. Raising out_ready -> handshake, in_ready=1 next cycle, next kernel correct.
6. Reset after 4 taps of scenario 1 -> all outputs 0 asynchronously. A fresh 9-tap unity kernel afterwards -> out_data=0x0900 (no residue).
